display_frame_buffer: RTL and testbench
=======================================

// Module: display_frame_buffer
// PURPOSE
//  Double-buffered LED-tile frame store driven by the Nios display_buffer addr/data/ctrl PIO exports.
//  Software writes the back buffer through edge-triggered ctrl strobes; the LED scan driver reads the front buffer.
//  Buffers swap only at a frame boundary, so the tile never shows a torn frame.
//  A hardware clear engine zeroes the back buffer without CPU loops. Sits between QSys PIOs and the LED scan logic.
// PARAMETERS
//  ADDR_W   11  word address width; each buffer holds 2**ADDR_W words
//  DATA_W   32  pixel word width; multiple of 8
// PORTS
//  clk_clk        in   1        system clock (single domain)
//  reset_reset    in   1        synchronous, active-high reset
//  db_addr        in   ADDR_W   PIO write address
//  db_data        in   DATA_W   PIO write data
//  db_ctrl        in   8        [0] wr strobe, [1] swap req, [2] clear req, [3] auto-inc, [7:4] byte mask (opt)
//  db_status      out  8        [0] clr_busy, [1] swap_pending, [2] front_sel, [3] wr_err, [7:4] 0
//  scan_addr      in   ADDR_W   front-buffer read address
//  scan_rd        in   1        read request
//  scan_data      out  DATA_W   read data
//  scan_valid     out  1        scan_data valid
//  scan_frame_end in   1        one-cycle pulse at the end of the frame scan
// BEHAVIOUR
//  - RAM is 2 x 2**ADDR_W x DATA_W: one write port (back buffer), one read port (front buffer).
//  - Reset: front_sel=0, swap_pending=0, wr_err=0, state IDLE, wr_ptr=0, scan_data=0, scan_valid=0.
//    RAM contents undefined. ctrl edge registers reset to all-ones, so bits held high through reset never fire.
//  - Edge detect: ev[i] = db_ctrl[i] & ~prev[i]; prev <= db_ctrl every cycle.
//  - Write (ev[0], state IDLE): commits on that clock edge to back buffer (~front_sel).
//    Address is wr_ptr if ctrl[3]=1, else db_addr. Then wr_ptr <= that address + 1, mod 2**ADDR_W (wraps).
//  - Write while CLEAR: dropped, wr_err <= 1 (sticky; cleared only by reset or a new clear request).
//  - FSM IDLE -> CLEAR on ev[2]: clr_busy=1, wr_err <= 0, clr_ptr from 0.
//    One zero word per cycle. CLEAR -> IDLE after word 2**ADDR_W-1, so busy lasts exactly 2**ADDR_W cycles.
//    ev[2] while in CLEAR is ignored.
//  - Swap: ev[1] sets swap_pending; repeat requests while pending are no-ops.
//    Swap fires when swap_pending & scan_frame_end & state IDLE: front_sel toggles, swap_pending <= 0.
//    If scan_frame_end arrives during CLEAR, the swap waits for the next scan_frame_end after CLEAR ends.
//  - Same cycle ev[1] & scan_frame_end: swap fires that cycle.
//  - Same cycle ev[0] & swap: the write targets the pre-swap back buffer.
//  - Read: scan_rd at cycle N -> scan_data/scan_valid at N+1 (1-cycle latency) from the front buffer sampled at N.
//    scan_valid=0 and scan_data holds when scan_rd=0.
//  - Reset during CLEAR: clear aborts, FSM returns to IDLE; the partially cleared buffer is not restored.
// CONFIGURATION
//  DISPLAY_FRAME_BUFFER_BYTEMASK_EN defined:
//    writes use byte enables db_ctrl[4 +: DATA_W/8]; DATA_W<=32 required.
//    Mask 0 counts as a write: wr_ptr advances, no bytes change.
//  Undefined: db_ctrl[7:4] ignored; every write is full-word. Clear is always full-word.
// TESTING
//  1 Reset; ctrl[0] edge addr=5 data=0xDEADBEEF; ev[1]; frame_end pulse; scan_rd addr=5
//    -> scan_data=0xDEADBEEF next cycle, front_sel=1.
//  2 ev[1] with no frame_end for 100 cycles -> swap_pending=1, front_sel unchanged;
//    frame_end pulse -> front_sel toggles, pending=0.
//  3 ev[2] (ADDR_W=4) -> clr_busy high exactly 16 cycles; write during clear -> wr_err=1, target word still 0 after swap.
//  4 ctrl[3]=1, addr=2**ADDR_W-1 then 3 strobes -> words at max, 0, 1 written; wr_ptr=2.
//  5 Reset asserted mid-clear; ctrl held 0x07 through reset
//    -> after release: IDLE, no write/swap/clear fires until the bits toggle.
//  6 BYTEMASK_EN: word=0x11223344, write 0xAABBCCDD mask=0b0101 -> readback 0x11BB33DD.

Source files
------------

// File: rtl/display_frame_buffer_if.sv
// PIO-side and scan-side signals of the double-buffered LED frame store.
// master drives requests (CPU PIOs and scan driver); slave is the frame buffer.
interface display_frame_buffer_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] db_addr;
  logic [DATA_W-1:0] db_data;
  logic [7:0]        db_ctrl;
  logic [7:0]        db_status;
  logic [ADDR_W-1:0] scan_addr;
  logic              scan_rd;
  logic [DATA_W-1:0] scan_data;
  logic              scan_valid;
  logic              scan_frame_end;

  modport master (
    output db_addr, db_data, db_ctrl, scan_addr, scan_rd, scan_frame_end,
    input  db_status, scan_data, scan_valid
  );

  modport slave (
    input  db_addr, db_data, db_ctrl, scan_addr, scan_rd, scan_frame_end,
    output db_status, scan_data, scan_valid
  );
endinterface

// File: rtl/display_frame_buffer.sv
// Double-buffered LED tile frame store with edge-triggered PIO writes, frame-aligned swap and clear engine.
// Define DISPLAY_FRAME_BUFFER_BYTEMASK_EN to enable per-byte write enables from db_ctrl[7:4].
module display_frame_buffer #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input logic                    clk_clk,
  input logic                    reset_reset,
  display_frame_buffer_if.slave  bus
);
  localparam int WORDS  = 2**ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q;
  logic [2:0]        prev_q;
  logic              front_sel_q;
  logic              swap_pending_q;
  logic              wr_err_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [DATA_W-1:0] scan_data_q;
  logic              scan_vld_q;

  logic [DATA_W-1:0] mem [2*WORDS];

  logic [2:0]        ev;
  logic [ADDR_W-1:0] wr_addr_d;
  logic              wr_fire;
  logic              swap_fire;
  logic              mem_we;
  logic [ADDR_W:0]   mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NBYTES-1:0] mem_be;
  logic [NBYTES-1:0] wr_be;

`ifdef DISPLAY_FRAME_BUFFER_BYTEMASK_EN
  assign wr_be = bus.db_ctrl[4 +: NBYTES];
`else
  logic unused_ctrl_mask;
  assign unused_ctrl_mask = ^bus.db_ctrl[7:4];
  assign wr_be = '1;
`endif

  assign ev        = bus.db_ctrl[2:0] & ~prev_q;
  assign wr_addr_d = bus.db_ctrl[3] ? wr_ptr_q : bus.db_addr;
  assign wr_fire   = ev[0] && (state_q == IDLE);
  // A request arriving with the frame-end pulse swaps in the same cycle.
  assign swap_fire = (swap_pending_q | ev[1]) & bus.scan_frame_end & (state_q == IDLE);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = {~front_sel_q, wr_addr_d};
    mem_wdata = bus.db_data;
    mem_be    = wr_be;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = {~front_sel_q, clr_ptr_q};
      mem_wdata = '0;
      mem_be    = '1;
    end else if (wr_fire) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (mem_be[b]) mem[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  // Read stage: front buffer sampled with the request, data one cycle later.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      scan_data_q <= '0;
      scan_vld_q  <= 1'b0;
    end else begin
      scan_vld_q <= bus.scan_rd;
      if (bus.scan_rd) scan_data_q <= mem[{front_sel_q, bus.scan_addr}];
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q        <= IDLE;
      prev_q         <= '1;
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      wr_err_q       <= 1'b0;
      wr_ptr_q       <= '0;
      clr_ptr_q      <= '0;
    end else begin
      prev_q <= bus.db_ctrl[2:0];
      if (wr_fire) wr_ptr_q <= wr_addr_d + ADDR_W'(1);
      if (swap_fire) begin
        front_sel_q    <= ~front_sel_q;
        swap_pending_q <= 1'b0;
      end else if (ev[1]) begin
        swap_pending_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (ev[2]) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            wr_err_q  <= 1'b0;
          end
        end
        CLEAR: begin
          if (ev[0]) wr_err_q <= 1'b1;
          clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
          if (clr_ptr_q == '1) state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.db_status  = {4'b0000, wr_err_q, front_sel_q, swap_pending_q, state_q == CLEAR};
  assign bus.scan_data  = scan_data_q;
  assign bus.scan_valid = scan_vld_q;
endmodule

// File: tb/tb_display_frame_buffer.sv
// Scoreboard bench for display_frame_buffer: a reference model predicts reads and status,
// expected read words are queued on request and checked when scan_valid appears.
module tb_display_frame_buffer;
  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  display_frame_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  display_frame_buffer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] sb [$];

  logic [DW-1:0] m_mem [2**(AW+1)];
  bit            m_front   = 1'b0;
  bit            m_pending = 1'b0;
  bit            m_err     = 1'b0;
  logic [AW-1:0] m_wptr    = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void m_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                  input bit ai, input logic [3:0] mk);
    logic [AW-1:0] wa;
    logic [DW-1:0] w;
    wa = ai ? m_wptr : a;
    w  = m_mem[{~m_front, wa}];
`ifdef DISPLAY_FRAME_BUFFER_BYTEMASK_EN
    for (int b = 0; b < DW/8; b++) if (mk[b]) w[b*8 +: 8] = d[b*8 +: 8];
`else
    if (mk == mk) w = d;
`endif
    m_mem[{~m_front, wa}] = w;
    m_wptr = wa + 1'b1;
  endfunction

  function automatic void m_fe();
    if (m_pending) begin
      m_front   = ~m_front;
      m_pending = 1'b0;
    end
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 2**AW; i++) m_mem[{~m_front, AW'(i)}] = '0;
    m_err = 1'b0;
  endfunction

  task automatic chk_status(input string tag);
    chk({tag, "_clr_busy"}, 32'(bus.db_status[0]), 32'(0));
    chk({tag, "_pending"},  32'(bus.db_status[1]), 32'(m_pending));
    chk({tag, "_front"},    32'(bus.db_status[2]), 32'(m_front));
    chk({tag, "_wr_err"},   32'(bus.db_status[3]), 32'(m_err));
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit ai, input logic [3:0] mk);
    @(negedge clk);
    bus.db_addr = a;
    bus.db_data = d;
    bus.db_ctrl = {mk, ai, 3'b001};
    m_write(a, d, ai, mk);
    @(negedge clk);
    bus.db_ctrl = {mk, ai, 3'b000};
  endtask

  task automatic swap_req();
    @(negedge clk);
    bus.db_ctrl = 8'h02;
    m_pending = 1'b1;
    @(negedge clk);
    bus.db_ctrl = 8'h00;
  endtask

  task automatic frame_end();
    @(negedge clk);
    bus.scan_frame_end = 1'b1;
    m_fe();
    @(negedge clk);
    bus.scan_frame_end = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    @(negedge clk);
    bus.scan_rd   = 1'b1;
    bus.scan_addr = a;
    sb.push_back(m_mem[{m_front, a}]);
    @(negedge clk);
    bus.scan_rd = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.scan_valid) begin
      if (sb.size() == 0) chk("scan_unexpected_valid", 32'(bus.scan_valid), 32'(0));
      else                chk("scan_data", bus.scan_data, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    bus.db_addr = '0; bus.db_data = '0; bus.db_ctrl = '0;
    bus.scan_addr = '0; bus.scan_rd = 1'b0; bus.scan_frame_end = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_status", 32'(bus.db_status), 32'(0));
    chk("rst_scan_valid", 32'(bus.scan_valid), 32'(0));
    chk("rst_scan_data", bus.scan_data, 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write, swap on frame end, read back; data holds when idle
    wr(5, 32'hDEADBEEF, 1'b0, 4'hF);
    swap_req();
    frame_end();
    chk_status("t1");
    rd(5);
    @(negedge clk);
    chk("t1_hold_valid", 32'(bus.scan_valid), 32'(0));
    chk("t1_hold_data", bus.scan_data, 32'hDEADBEEF);

    // Pending swap waits for the frame end
    swap_req();
    repeat (100) @(negedge clk);
    swap_req();
    chk_status("t2_wait");
    frame_end();
    chk_status("t2_swap");
    @(negedge clk);
    bus.db_ctrl = 8'h02; bus.scan_frame_end = 1'b1;
    m_pending = 1'b1; m_fe();
    @(negedge clk);
    bus.db_ctrl = 8'h00; bus.scan_frame_end = 1'b0;
    chk_status("t2_same_cycle");
    swap_req();
    @(negedge clk);
    bus.db_addr = 6; bus.db_data = 32'h600D600D; bus.db_ctrl = 8'hF1; bus.scan_frame_end = 1'b1;
    m_write(6, 32'h600D600D, 1'b0, 4'hF); m_fe();
    @(negedge clk);
    bus.db_ctrl = 8'h00; bus.scan_frame_end = 1'b0;
    chk_status("t2_wr_swap");
    rd(6);

    // Clear engine: busy length, write during clear, deferred swap
    wr(3, 32'hCAFEF00D, 1'b0, 4'hF);
    @(negedge clk);
    bus.db_ctrl = 8'h04;
    m_clear();
    busy_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.db_status[0]) busy_cnt++;
      case (n)
        0: bus.db_ctrl = 8'h00;
        1: begin bus.db_ctrl = 8'h02; m_pending = 1'b1; end
        2: bus.db_ctrl = 8'h00;
        3: begin bus.db_addr = 3; bus.db_data = 32'hFFFFFFFF; bus.db_ctrl = 8'hF1; m_err = 1'b1; end
        4: bus.db_ctrl = 8'h00;
        6: bus.scan_frame_end = 1'b1;
        7: bus.scan_frame_end = 1'b0;
        default: ;
      endcase
    end
    chk("t3_busy_cycles", 32'(busy_cnt), 32'd16);
    chk_status("t3_after_clear");
    frame_end();
    chk_status("t3_swapped");
    rd(3);
    rd(0);
    rd(15);

    // Auto-increment wraps past the top address
    wr(15, 32'hA0A0A0A0, 1'b0, 4'hF);
    wr(0, 32'hB1B1B1B1, 1'b1, 4'hF);
    wr(0, 32'hC2C2C2C2, 1'b1, 4'hF);
    wr(0, 32'hD3D3D3D3, 1'b1, 4'hF);
    swap_req();
    frame_end();
    rd(15); rd(0); rd(1); rd(2);

    // Reset during clear with ctrl held high
    @(negedge clk);
    bus.db_ctrl = 8'h04;
    @(negedge clk);
    bus.db_ctrl = 8'h00;
    m_err = 1'b0;
    chk("t5_busy", 32'(bus.db_status[0]), 32'(1));
    chk("t5_err_cleared", 32'(bus.db_status[3]), 32'(0));
    repeat (3) @(negedge clk);
    bus.db_ctrl = 8'h07; bus.db_addr = 9; bus.db_data = 32'h00000BAD;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_front = 1'b0; m_pending = 1'b0; m_err = 1'b0; m_wptr = '0;
    repeat (2) @(negedge clk);
    bus.scan_frame_end = 1'b1;
    @(negedge clk);
    bus.scan_frame_end = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_status", 32'(bus.db_status), 32'(0));
    bus.db_ctrl = 8'h00;
    repeat (2) @(negedge clk);
    wr(0, 32'h00000055, 1'b1, 4'hF);
    swap_req();
    frame_end();
    chk_status("t5_final");
    rd(0);

`ifdef DISPLAY_FRAME_BUFFER_BYTEMASK_EN
    // Byte-masked writes
    wr(4, 32'h11223344, 1'b0, 4'hF);
    wr(4, 32'hAABBCCDD, 1'b0, 4'b0101);
    wr(4, 32'hFFFFFFFF, 1'b0, 4'b0000);
    wr(0, 32'h00000077, 1'b1, 4'hF);
    swap_req();
    frame_end();
    rd(4);
    rd(5);
    chk("t6_model", m_mem[{m_front, 4'd4}], 32'h11BB33DD);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
